// File: rtl/lfsr_checker.sv
// Tracks a received 32-bit Galois LFSR state stream: seeds from the link, locks after
// enough correct predictions, then free-runs and counts every mismatching word.
module lfsr_checker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int CNT_W      = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt
);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic [3:0]       LOCK_TGT   = 4'(LOCK_CNT);
   localparam logic [3:0]       UNLOCK_TGT = 4'(UNLOCK_CNT);
   localparam logic [31:0]      PRED_INIT  = 32'h0000_0001;
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

   function automatic logic [31:0] f_step(input logic [31:0] s);
      f_step = {s[0], s[31:24], s[23] ^ s[0], s[22:3], s[2] ^ s[0], s[1] ^ s[0]};
   endfunction

   state_t           r_state;
   state_t           w_state_next;
   logic [31:0]      r_pred;
   logic [31:0]      w_pred_next;
   logic [3:0]       r_good_cnt;
   logic [3:0]       w_good_cnt_next;
   logic [3:0]       r_bad_cnt;
   logic [3:0]       w_bad_cnt_next;
   logic             r_seeded;
   logic             w_seeded_next;
   logic             r_err_pulse;
   logic             w_err_pulse_next;
   logic [CNT_W-1:0] r_err_cnt;
   logic [CNT_W-1:0] w_err_cnt_next;

   logic             w_match;
   logic [31:0]      w_step_in;
   logic [31:0]      w_step_pred;
   logic [3:0]       w_good_inc;
   logic [3:0]       w_bad_inc;
   logic [CNT_W-1:0] w_err_inc;

   // An all-zero word is the LFSR lock-up state and can never be a valid match.
   assign w_match     = (|in_data) && (in_data == r_pred);
   assign w_step_in   = f_step(in_data);
   assign w_step_pred = f_step(r_pred);
   assign w_good_inc  = r_good_cnt + 4'd1;
   assign w_bad_inc   = r_bad_cnt + 4'd1;
   assign w_err_inc   = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + 1'b1;

   always_comb begin
      w_state_next     = r_state;
      w_pred_next      = r_pred;
      w_good_cnt_next  = r_good_cnt;
      w_bad_cnt_next   = r_bad_cnt;
      w_seeded_next    = r_seeded;
      w_err_pulse_next = 1'b0;
      w_err_cnt_next   = r_err_cnt;

      if (in_valid) begin
         case (r_state)
            ST_SEARCH: begin
               if (!r_seeded) begin
                  w_pred_next     = w_step_in;
                  w_seeded_next   = 1'b1;
                  w_good_cnt_next = 4'd0;
               end else if (w_match) begin
                  w_pred_next     = w_step_in;
                  w_good_cnt_next = w_good_inc;
                  if (w_good_inc == LOCK_TGT) begin
                     w_state_next   = ST_LOCKED;
                     w_bad_cnt_next = 4'd0;
                  end
               end else begin
                  w_good_cnt_next = 4'd0;
                  if (|in_data) begin
                     w_pred_next = w_step_in;
                  end else begin
                     w_seeded_next = 1'b0;
                  end
               end
            end
            ST_LOCKED: begin
               // Prediction free-runs so one corrupted word costs exactly one error.
               w_pred_next = w_step_pred;
               if (w_match) begin
                  w_bad_cnt_next = 4'd0;
               end else begin
                  w_bad_cnt_next   = w_bad_inc;
                  w_err_pulse_next = 1'b1;
                  w_err_cnt_next   = w_err_inc;
                  if (w_bad_inc == UNLOCK_TGT) begin
                     w_state_next    = ST_SEARCH;
                     w_seeded_next   = 1'b0;
                     w_good_cnt_next = 4'd0;
                  end
               end
            end
            default: begin
               w_state_next = ST_SEARCH;
            end
         endcase
      end

      if (clr_cnt) begin
         w_err_cnt_next = '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state     <= ST_SEARCH;
         r_pred      <= PRED_INIT;
         r_good_cnt  <= 4'd0;
         r_bad_cnt   <= 4'd0;
         r_seeded    <= 1'b0;
         r_err_pulse <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_state     <= w_state_next;
         r_pred      <= w_pred_next;
         r_good_cnt  <= w_good_cnt_next;
         r_bad_cnt   <= w_bad_cnt_next;
         r_seeded    <= w_seeded_next;
         r_err_pulse <= w_err_pulse_next;
         r_err_cnt   <= w_err_cnt_next;
      end
   end

   assign locked    = (r_state == ST_LOCKED);
   assign err_pulse = r_err_pulse;
   assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomized bench for lfsr_checker: a word-level reference model, with a default and a
// 4-bit-counter instance driven by the same stimulus.
module tb_lfsr_checker;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = 32'h0;
   logic        clr_cnt = 1'b0;

   logic        locked;
   logic        err_pulse;
   logic [15:0] err_cnt;
   logic        locked4;
   logic        err_pulse4;
   logic [3:0]  err_cnt4;

   always #5 sys_clk = ~sys_clk;

   lfsr_checker u_dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   lfsr_checker #(.CNT_W(4)) u_dut4 (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_cnt   (clr_cnt),
      .locked    (locked4),
      .err_pulse (err_pulse4),
      .err_cnt   (err_cnt4)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_cyc   = 0;

   // Reference model state, word level
   bit          m_locked;
   bit          m_seeded;
   bit          m_pulse;
   int          m_good;
   int          m_bad;
   int          m_err;
   logic [31:0] m_pred;
   logic [31:0] g;

   // Galois generator as shift plus feedback mask
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8040_0003 : 32'h0);
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, n_cyc);
      end
   endtask

   task automatic model_step(input bit v, input logic [31:0] d, input bit c, input bit r);
      bit hit;
      if (r) begin
         m_locked = 0; m_seeded = 0; m_good = 0; m_bad = 0;
         m_pred = 32'h1; m_pulse = 0; m_err = 0;
         return;
      end
      m_pulse = 0;
      if (v) begin
         hit = (d == m_pred) && (d != 32'h0);
         if (m_locked) begin
            m_pred = lfsr_next(m_pred);
            if (hit) m_bad = 0;
            else begin
               m_bad++;
               m_pulse = 1;
               m_err++;
               if (m_bad == 3) begin
                  m_locked = 0; m_seeded = 0; m_good = 0;
               end
            end
         end else if (!m_seeded) begin
            m_pred = lfsr_next(d); m_seeded = 1; m_good = 0;
         end else if (hit) begin
            m_pred = lfsr_next(d);
            m_good++;
            if (m_good == 4) begin
               m_locked = 1; m_bad = 0;
            end
         end else begin
            m_good = 0;
            if (d == 32'h0) m_seeded = 0;
            else m_pred = lfsr_next(d);
         end
      end
      if (c) m_err = 0;
   endtask

   task automatic cycle(input bit v, input logic [31:0] d, input bit c, input bit r);
      @(negedge sys_clk);
      in_valid = v; in_data = d; clr_cnt = c; sys_rst = r;
      @(posedge sys_clk);
      model_step(v, d, c, r);
      #1;
      n_cyc++;
      $display("[TB] cyc=%0d rst=%0b v=%0b d=%08h clr=%0b -> locked=%0b pulse=%0b cnt=%0d cnt4=%0d",
               n_cyc, r, v, d, c, locked, err_pulse, err_cnt, err_cnt4);
      check_eq("locked",  32'(locked),     32'(m_locked));
      check_eq("pulse",   32'(err_pulse),  32'(m_pulse));
      check_eq("cnt",     32'(err_cnt),    32'(sat(m_err, 65535)));
      check_eq("locked4", 32'(locked4),    32'(m_locked));
      check_eq("pulse4",  32'(err_pulse4), 32'(m_pulse));
      check_eq("cnt4",    32'(err_cnt4),   32'(sat(m_err, 15)));
   endtask

   task automatic good_word(input bit v);
      if (v) begin
         cycle(1'b1, g, 1'b0, 1'b0);
         g = lfsr_next(g);
      end else begin
         cycle(1'b0, $urandom, 1'b0, 1'b0);
      end
   endtask

   task automatic bad_word(input logic [31:0] d, input bit c);
      cycle(1'b1, d, c, 1'b0);
      g = lfsr_next(g);
   endtask

   initial begin
      int nv;
      int k;
      logic [31:0] d;
      bit v;
      bit c;

      // Reset, overriding valid and clear
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 32'h0000_dead, 1'b1, 1'b1);
      check_eq("rst_locked", 32'(locked), 32'h0);
      check_eq("rst_pulse", 32'(err_pulse), 32'h0);
      check_eq("rst_cnt", 32'(err_cnt), 32'h0);

      // Continuous clean stream from seed 1
      g = 32'h1;
      for (int i = 1; i <= 1000; i++) begin
         good_word(1'b1);
         if (i == 4) check_eq("lock_early", 32'(locked), 32'h0);
         if (i == 5) check_eq("lock_5th", 32'(locked), 32'h1);
      end
      check_eq("clean_cnt", 32'(err_cnt), 32'h0);
      check_eq("clean_locked", 32'(locked), 32'h1);

      // Single bit-7 flip
      bad_word(g ^ 32'h80, 1'b0);
      check_eq("flip_pulse", 32'(err_pulse), 32'h1);
      check_eq("flip_cnt", 32'(err_cnt), 32'h1);
      check_eq("flip_locked", 32'(locked), 32'h1);
      good_word(1'b1);
      check_eq("flip_pulse_end", 32'(err_pulse), 32'h0);
      for (int i = 0; i < 10; i++) good_word(1'b1);
      check_eq("flip_cnt_hold", 32'(err_cnt), 32'h1);

      // Three zero words force SEARCH, then relock
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check_eq("clr_idle", 32'(err_cnt), 32'h0);
      bad_word(32'h0, 1'b0);
      bad_word(32'h0, 1'b0);
      check_eq("zero2_locked", 32'(locked), 32'h1);
      bad_word(32'h0, 1'b0);
      check_eq("zero3_locked", 32'(locked), 32'h0);
      check_eq("zero3_cnt", 32'(err_cnt), 32'h3);
      for (int i = 1; i <= 5; i++) begin
         good_word(1'b1);
         if (i == 4) check_eq("relock_early", 32'(locked), 32'h0);
         if (i == 5) check_eq("relock", 32'(locked), 32'h1);
      end

      // Drive the narrow counter into saturation with isolated errors
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         bad_word(g ^ (32'h1 << (i % 32)), 1'b0);
         good_word(1'b1);
      end
      check_eq("sat_cnt4", 32'(err_cnt4), 32'd15);
      check_eq("sat_cnt16", 32'(err_cnt), 32'd20);
      check_eq("sat_locked", 32'(locked), 32'h1);
      bad_word(g ^ 32'h4, 1'b1);
      check_eq("clr_win_cnt", 32'(err_cnt), 32'h0);
      check_eq("clr_win_cnt4", 32'(err_cnt4), 32'h0);
      check_eq("clr_win_pulse", 32'(err_pulse), 32'h1);
      good_word(1'b1);

      // Reset while locked discards lock
      bad_word(g ^ 32'h1, 1'b0);
      cycle(1'b1, g, 1'b0, 1'b1);
      check_eq("rstlk_locked", 32'(locked), 32'h0);
      check_eq("rstlk_pulse", 32'(err_pulse), 32'h0);
      check_eq("rstlk_cnt", 32'(err_cnt), 32'h0);
      for (int i = 1; i <= 5; i++) begin
         good_word(1'b1);
         if (i == 4) check_eq("rstlk_early", 32'(locked), 32'h0);
         if (i == 5) check_eq("rstlk_relock", 32'(locked), 32'h1);
      end

      // Random gaps over a clean stream
      cycle(1'b0, 32'h0, 1'b0, 1'b1);
      g = 32'h1;
      nv = 0;
      for (int i = 0; i < 400; i++) begin
         v = 1'($urandom_range(0, 1));
         good_word(v);
         if (v) nv++;
         check_eq("gap_locked", 32'(locked), (nv >= 5) ? 32'h1 : 32'h0);
         check_eq("gap_cnt", 32'(err_cnt), 32'h0);
      end

      // Random mix of gaps, corruption, clears and resets
      for (int i = 0; i < 800; i++) begin
         v = ($urandom % 4) != 0;
         c = ($urandom % 50) == 0;
         if (($urandom % 300) == 0) begin
            cycle(v, g, c, 1'b1);
            g = 32'h1;
         end else if (!v) begin
            cycle(1'b0, $urandom, c, 1'b0);
         end else begin
            k = int'($urandom % 32);
            if (k == 0)     d = 32'h0;
            else if (k < 3) d = g ^ (32'h1 << ($urandom % 32));
            else if (k == 3) d = $urandom;
            else            d = g;
            cycle(1'b1, d, c, 1'b0);
            g = lfsr_next(g);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
